// File: rtl/lsu_fault_pipe.sv
// LSU fault pipeline: carries DC1 fault verdicts through DC2/DC3 and presents one exception
// at a time to the trap logic over valid/ack, with overrun flag and saturating fault counter.
module lsu_fault_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_freeze,
    input  logic             flush_all,
    input  logic             pkt_valid_dc1,
    input  logic             pkt_store_dc1,
    input  logic             pkt_dma_dc1,
    input  logic [31:0]      start_addr_dc1,
    input  logic             access_fault_dc1,
    input  logic             misaligned_fault_dc1,
    input  logic             exc_ack,
    output logic             exc_valid,
    output logic             exc_type,
    output logic             exc_store,
    output logic [31:0]      exc_addr,
    output logic             exc_pending,
    output logic             exc_overrun,
    output logic [CNT_W-1:0] fault_cnt
);

    typedef enum logic {StIdle, StHold} state_e;

    logic        dc1_fault;
    logic        dc1_type;
    logic        present;

    logic        dc2_valid_q, dc2_fault_q, dc2_type_q, dc2_store_q;
    logic [31:0] dc2_addr_q;
    logic        dc3_valid_q, dc3_fault_q, dc3_type_q, dc3_store_q;
    logic [31:0] dc3_addr_q;

    state_e           state_q;
    logic             hold_type_q;
    logic             hold_store_q;
    logic [31:0]      hold_addr_q;
    logic             overrun_q;
    logic [CNT_W-1:0] cnt_q;

    // Misaligned wins when both verdicts are set, so type is simply its inverse.
    assign dc1_fault = (access_fault_dc1 | misaligned_fault_dc1) & pkt_valid_dc1 & ~pkt_dma_dc1;
    assign dc1_type  = ~misaligned_fault_dc1;
    assign present   = dc3_valid_q & dc3_fault_q & ~lsu_freeze & ~flush_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc2_valid_q <= 1'b0;
            dc2_fault_q <= 1'b0;
            dc2_type_q  <= 1'b0;
            dc2_store_q <= 1'b0;
            dc2_addr_q  <= '0;
            dc3_valid_q <= 1'b0;
            dc3_fault_q <= 1'b0;
            dc3_type_q  <= 1'b0;
            dc3_store_q <= 1'b0;
            dc3_addr_q  <= '0;
        end else if (flush_all) begin
            dc2_valid_q <= 1'b0;
            dc3_valid_q <= 1'b0;
        end else if (!lsu_freeze) begin
            dc2_valid_q <= pkt_valid_dc1;
            dc2_fault_q <= dc1_fault;
            dc2_type_q  <= dc1_type;
            dc2_store_q <= pkt_store_dc1;
            dc2_addr_q  <= start_addr_dc1;
            dc3_valid_q <= dc2_valid_q;
            dc3_fault_q <= dc2_fault_q;
            dc3_type_q  <= dc2_type_q;
            dc3_store_q <= dc2_store_q;
            dc3_addr_q  <= dc2_addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_type_q  <= 1'b0;
            hold_store_q <= 1'b0;
            hold_addr_q  <= '0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // Dropped faults still count, so the counter only looks at present.
            if (present && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (flush_all) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (present && !exc_ack) begin
                            state_q      <= StHold;
                            hold_type_q  <= dc3_type_q;
                            hold_store_q <= dc3_store_q;
                            hold_addr_q  <= dc3_addr_q;
                        end
                    end
                    StHold: begin
                        if (exc_ack) begin
                            state_q   <= StIdle;
                            overrun_q <= 1'b0;
                        end else if (present) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        exc_valid   = present;
        exc_type    = dc3_type_q;
        exc_store   = dc3_store_q;
        exc_addr    = dc3_addr_q;
        exc_pending = 1'b0;
        if (state_q == StHold) begin
            exc_valid   = 1'b1;
            exc_type    = hold_type_q;
            exc_store   = hold_store_q;
            exc_addr    = hold_addr_q;
            exc_pending = 1'b1;
        end
    end

    assign exc_overrun = overrun_q;
    assign fault_cnt   = cnt_q;

endmodule
